// File: rtl/wb_uart_pkg.sv
// Shared constants and types for the Wishbone UART transmitter.
// Register map, STATUS bit layout and the serializer state encoding.
package wb_uart_pkg;

  localparam int DIV_W = 16;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone B4 classic bus bundle shared by the interconnect ports.
// Masters drive the request; slaves return data and ack.
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// A push at full is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rp];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-attached 8N1 UART transmitter with TX FIFO.
// Registers: TXDATA, STATUS (W1C OVF), DIVISOR, CTRL.EN.
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int               FIFO_DEPTH  = 8,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = 16'd433
) (
  input  logic clk_in,
  input  logic reset_in,
  wb_bus.slave bus_slave,
  output logic tx_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_en;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic             w_req;
  logic             w_wr;
  logic             w_sel_st;
  logic             w_sel_div;
  logic             w_sel_ctl;
  logic [1:0]       w_reg;
  logic [31:0]      w_rdata;
  logic             w_unused;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CW-1:0]    w_count;

  tx_state_e        r_state;
  tx_state_e        w_state;
  logic [DIV_W-1:0] r_baud;
  logic [DIV_W-1:0] w_baud;
  logic [DIV_W-1:0] r_bdiv;
  logic [DIV_W-1:0] w_bdiv;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift;
  logic             r_tx;
  logic             w_tx;
  logic             w_tick;
  logic             w_go;

  assign w_req     = bus_slave.cyc & bus_slave.stb & ~r_ack;
  assign w_wr      = w_req & bus_slave.we;
  assign w_reg     = bus_slave.adr[3:2];
  assign w_sel_st  = (w_reg == REG_STATUS);
  assign w_sel_div = (w_reg == REG_DIVISOR);
  assign w_sel_ctl = (w_reg == REG_CTRL);
  assign w_push    = w_wr & (w_reg == REG_TXDATA);
  assign w_unused  = ^{bus_slave.sel, bus_slave.adr[31:4],
                       bus_slave.adr[1:0], bus_slave.dat_w[31:16]};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_st: begin
        w_rdata[ST_FULL]       = w_full;
        w_rdata[ST_EMPTY]      = w_empty;
        w_rdata[ST_BUSY]       = (r_state != S_IDLE);
        w_rdata[ST_OVF]        = r_ovf;
        w_rdata[ST_CNT +: 4]   = 4'(w_count);
      end
      w_sel_div: w_rdata[DIV_W-1:0] = r_div;
      w_sel_ctl: w_rdata[0]         = r_en;
      default:   w_rdata            = '0;
    endcase
  end

  // All register side effects happen on the edge that raises ACK.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_en  <= 1'b0;
      r_ovf <= 1'b0;
      r_div <= DIV_DEFAULT;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~bus_slave.we) ? w_rdata : '0;
      if (w_wr & w_sel_ctl) r_en  <= bus_slave.dat_w[0];
      if (w_wr & w_sel_div) r_div <= bus_slave.dat_w[DIV_W-1:0];
      if (w_push & w_full & ~w_pop)
        r_ovf <= 1'b1;
      else if (w_wr & w_sel_st & bus_slave.dat_w[ST_OVF])
        r_ovf <= 1'b0;
    end
  end

  assign bus_slave.ack   = r_ack;
  assign bus_slave.dat_r = r_dat;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (reset_in),
    .push  (w_push),
    .din   (bus_slave.dat_w[7:0]),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Bit period is latched at each boundary so DIVISOR writes never cut a bit.
  assign w_tick = (r_baud == r_bdiv);
  assign w_go   = r_en & ~w_empty;

  always_comb begin
    w_state = r_state;
    w_baud  = r_baud + 1'b1;
    w_bdiv  = r_bdiv;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_pop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud = '0;
        if (w_go) begin
          w_state = S_START;
          w_pop   = 1'b1;
          w_shift = w_head;
          w_bdiv  = r_div;
        end
      end
      S_START: if (w_tick) begin
        w_state = S_DATA;
        w_bit   = '0;
        w_baud  = '0;
        w_bdiv  = r_div;
      end
      S_DATA: if (w_tick) begin
        w_baud  = '0;
        w_bdiv  = r_div;
        w_shift = r_shift >> 1;
        if (r_bit == 3'd7) w_state = S_STOP;
        else               w_bit   = r_bit + 1'b1;
      end
      S_STOP: if (w_tick) begin
        w_baud = '0;
        w_bdiv = r_div;
        if (w_go) begin
          w_state = S_START;
          w_pop   = 1'b1;
          w_shift = w_head;
        end else begin
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_tx = 1'b1;
    if (w_state == S_START)     w_tx = 1'b0;
    else if (w_state == S_DATA) w_tx = w_shift[0];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bdiv  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bdiv  <= w_bdiv;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
    end
  end

  assign tx_out = r_tx;

endmodule

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of TX FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DIV_DEFAULT, default 16'd433, reset value of DIVISOR; clocks per bit = DIVISOR+1.
REQ-003 clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 bus_slave  wb_bus slave modport  -  Wishbone B4 classic responder (CYC, STB, WE, ADR, SEL, write data, read data, ACK); SEL ignored.
REQ-006 tx_out  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-007 Register decode on ADR[3:2]: 0 TXDATA (W), 1 STATUS (R/W1C), 2 DIVISOR (RW, 16b), 3 CTRL (RW, bit0 EN); ADR[1:0] and upper bits ignored.
REQ-008 ACK registered: request sampled with CYC&STB at cycle N produces single-cycle ACK at N+1; ack_next = CYC & STB & ~ACK, giving a new transfer at most every second cycle.
REQ-009 Register side effects occur exactly once per transfer, in the cycle ACK is registered; read data is valid while ACK is high, 0 outside.
REQ-010 TXDATA write pushes DAT[7:0]; TXDATA reads return 0.
REQ-011 Push while FIFO full and no same-cycle pop: data dropped, STATUS.OVF set (sticky).
REQ-012 Push and pop in the same cycle at full: push accepted, count unchanged.
REQ-013 STATUS read: bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVF, bits[11:8] FIFO count, others 0; writing 1 to bit3 clears OVF; other bits read-only.
REQ-014 FSM states IDLE, START, DATA, STOP; IDLE to START when EN=1 and FIFO non-empty, popping the head into the shift register that cycle.
REQ-015 Each state lasts DIVISOR+1 clocks; tx_out = 0 in START, shift[0] in DATA (8 bits, counter 0..7), 1 in STOP and IDLE.
REQ-016 From STOP: to START with immediate pop if EN=1 and FIFO non-empty (back-to-back frames, no idle gap), else IDLE.
REQ-017 DIVISOR written mid-frame takes effect at the next bit boundary; DIVISOR=0 gives one clock per bit.
REQ-018 EN cleared mid-frame: current frame completes; no further frame starts; FIFO contents retained.
REQ-019 tx_out driven from a register (glitch-free).

Reset
REQ-020 On reset_in=1 at a clock edge: FSM IDLE, tx_out 1, ACK 0, FIFO empty, OVF 0, EN 0, DIVISOR DIV_DEFAULT, bit/baud counters 0.
REQ-021 Reset mid-frame aborts the frame; tx_out 1 the following cycle; any in-flight bus transfer is dropped without ACK.

Structure
REQ-022 Package wb_uart_pkg SHALL hold register offset constants, STATUS bit positions, the FSM state enum and the 16-bit divisor width.
REQ-023 FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count), same clock and reset.
REQ-024 Block SHALL attach to one interconnect peripheral port via the existing wb_bus interface, no other changes.

Verification
REQ-025 Reset, DIVISOR=3, EN=1, write TXDATA=0x55 -> tx_out: 4 clk low, then 1,0,1,0,1,0,1,0 at 4 clk each, 4 clk high; BUSY high for 40 clk.
REQ-026 Read STATUS at reset -> ACK at N+1 only, data 0x0000_0002; DIVISOR reads 433, CTRL reads 0.
REQ-027 EN=0, write 9 bytes with FIFO_DEPTH=8 -> STATUS FULL=1, OVF=1, count=8; write 0x8 to STATUS -> OVF=0.
REQ-028 DIVISOR=0, EN=1, write 0xA5 and 0x3C -> two 10-clk frames back-to-back, no idle cycle between STOP and second START.
REQ-029 Assert reset_in during DATA bit 4 -> tx_out 1 next cycle, STATUS reads EMPTY=1, BUSY=0, OVF=0, DIVISOR=433.
REQ-030 Clear EN during frame 1 with 2 bytes queued -> frame 1 completes, line stays high, count=1; set EN -> remaining byte sent.
